// File: rtl/tag_scm_ctrl_if.sv
// ---------------------------------------------------------------------------
// tag_scm_ctrl_if
// Purpose : bus between the tag-bank initiator (tag_scm_ctrl) and the
//           single-port tag memory. The memory returns read data one cycle
//           after a read request.
// Signals : tag_req_o    memory request
//           tag_write_o  1 = write, 0 = read
//           tag_addr_o   set index
//           tag_wdata_o  entry to write, {valid, tag}
//           tag_rdata_i  entry read, valid the cycle after a read request
// Modports: master = controller side, slave = memory side
// ---------------------------------------------------------------------------
interface tag_scm_ctrl_if #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 6
);

  logic                  tag_req_o;
  logic                  tag_write_o;
  logic [ADDR_WIDTH-1:0] tag_addr_o;
  logic [DATA_WIDTH-1:0] tag_wdata_o;
  logic [DATA_WIDTH-1:0] tag_rdata_i;

  modport master (
    output tag_req_o,
    output tag_write_o,
    output tag_addr_o,
    output tag_wdata_o,
    input  tag_rdata_i
  );

  modport slave (
    input  tag_req_o,
    input  tag_write_o,
    input  tag_addr_o,
    input  tag_wdata_o,
    output tag_rdata_i
  );

endinterface

// File: rtl/tag_scm_ctrl.sv
// ---------------------------------------------------------------------------
// tag_scm_ctrl
// Purpose : initiator for a single-port tag bank. Invalidates every entry
//           after reset and on flush, arbitrates refill writes against
//           lookups (one memory access per cycle), and returns a hit/miss
//           result one cycle after each granted lookup.
// Ports   : clk, rst_n            clock, asynchronous active-low reset
//           flush_req_i/_ack_o    level flush request, one-cycle completion
//           busy_o                high while sweeping the bank
//           refill_*              write {1'b1, tag} to a set index
//           lookup_*              read a set index and compare a tag
//           tag_if                tag memory bus (master side)
// ---------------------------------------------------------------------------
module tag_scm_ctrl #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_req_i,
  output logic                  flush_ack_o,
  output logic                  busy_o,
  input  logic                  refill_req_i,
  output logic                  refill_gnt_o,
  input  logic [ADDR_WIDTH-1:0] refill_index_i,
  input  logic [DATA_WIDTH-2:0] refill_tag_i,
  input  logic                  lookup_req_i,
  output logic                  lookup_gnt_o,
  input  logic [ADDR_WIDTH-1:0] lookup_index_i,
  input  logic [DATA_WIDTH-2:0] lookup_tag_i,
  output logic                  lookup_rvalid_o,
  output logic                  lookup_hit_o,
  tag_scm_ctrl_if.master        tag_if
);

  localparam int                    TAG_WIDTH = DATA_WIDTH - 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_SET  = '1;
  localparam logic [ADDR_WIDTH-1:0] ONE       = 1;

  typedef enum logic {
    FLUSH,
    IDLE
  } state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [ADDR_WIDTH-1:0] r_count;
  logic [ADDR_WIDTH-1:0] w_countNext;
  logic                  r_ackPending;
  logic                  w_ackPendingNext;
  logic                  r_flushAck;
  logic                  w_flushAckNext;
  logic                  r_needLow;
  logic                  w_flushBlocked;
  logic                  r_lookupValid;
  logic [TAG_WIDTH-1:0]  r_lookupTag;
  logic                  w_refillGnt;
  logic                  w_lookupGnt;

  // A flush request that is still high in the ack cycle (or after it) must
  // not start another sweep; the requester has to show a 0 first.
  assign w_flushBlocked = r_flushAck | r_needLow;

  // State register, sweep counter and flush-ack bookkeeping. Reset starts a
  // sweep from address 0 and discards any ack owed to an earlier request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FLUSH;
      r_count      <= '0;
      r_ackPending <= 1'b0;
      r_flushAck   <= 1'b0;
      r_needLow    <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_count      <= w_countNext;
      r_ackPending <= w_ackPendingNext;
      r_flushAck   <= w_flushAckNext;
      r_needLow    <= (r_flushAck | r_needLow) & flush_req_i;
    end
  end

  // Next state, grants and the memory bus. FLUSH writes one zeroed entry per
  // cycle; IDLE gives the single memory slot to flush, then refill, then
  // lookup. The bus is held quiet while rst_n is low so nothing is written
  // before the sweep really begins.
  always_comb begin
    w_stateNext         = r_state;
    w_countNext         = r_count;
    w_ackPendingNext    = r_ackPending;
    w_flushAckNext      = 1'b0;
    w_refillGnt         = 1'b0;
    w_lookupGnt         = 1'b0;
    tag_if.tag_req_o    = 1'b0;
    tag_if.tag_write_o  = 1'b0;
    tag_if.tag_addr_o   = '0;
    tag_if.tag_wdata_o  = '0;
    case (r_state)
      FLUSH: begin
        if (rst_n) begin
          tag_if.tag_req_o   = 1'b1;
          tag_if.tag_write_o = 1'b1;
          tag_if.tag_addr_o  = r_count;
        end
        w_countNext = r_count + ONE;
        if (r_count == LAST_SET) begin
          w_stateNext      = IDLE;
          w_flushAckNext   = r_ackPending;
          w_ackPendingNext = 1'b0;
        end
      end
      IDLE: begin
        if (flush_req_i && !w_flushBlocked) begin
          w_stateNext      = FLUSH;
          w_countNext      = '0;
          w_ackPendingNext = 1'b1;
        end else if (refill_req_i) begin
          w_refillGnt        = 1'b1;
          tag_if.tag_req_o   = 1'b1;
          tag_if.tag_write_o = 1'b1;
          tag_if.tag_addr_o  = refill_index_i;
          tag_if.tag_wdata_o = {1'b1, refill_tag_i};
        end else if (lookup_req_i) begin
          w_lookupGnt       = 1'b1;
          tag_if.tag_req_o  = 1'b1;
          tag_if.tag_addr_o = lookup_index_i;
        end
      end
      default: begin
        w_stateNext = FLUSH;
        w_countNext = '0;
      end
    endcase
  end

  // Lookup pipeline: the compare tag waits one cycle for the read data. A
  // lookup granted just before a flush is accepted still completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lookupValid <= 1'b0;
      r_lookupTag   <= '0;
    end else begin
      r_lookupValid <= w_lookupGnt;
      if (w_lookupGnt) begin
        r_lookupTag <= lookup_tag_i;
      end
    end
  end

  assign flush_ack_o     = r_flushAck;
  assign busy_o          = (r_state == FLUSH);
  assign refill_gnt_o    = w_refillGnt;
  assign lookup_gnt_o    = w_lookupGnt;
  assign lookup_rvalid_o = r_lookupValid;
  assign lookup_hit_o    = r_lookupValid & tag_if.tag_rdata_i[DATA_WIDTH-1] &
                           (tag_if.tag_rdata_i[DATA_WIDTH-2:0] == r_lookupTag);

endmodule

// File: tb/tb_tag_scm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tag_scm_ctrl
// Purpose : directed bench for tag_scm_ctrl with a behavioural single-port
//           tag memory, a reference tag model and a queue of expected
//           lookup results.
// ---------------------------------------------------------------------------
module tb_tag_scm_ctrl;

  localparam int DW    = 7;
  localparam int AW    = 6;
  localparam int TW    = DW - 1;
  localparam int NSETS = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flushReq = 1'b0;
  logic          flushAck;
  logic          busy;
  logic          refillReq = 1'b0;
  logic          refillGnt;
  logic [AW-1:0] refillIndex = '0;
  logic [TW-1:0] refillTag = '0;
  logic          lookupReq = 1'b0;
  logic          lookupGnt;
  logic [AW-1:0] lookupIndex = '0;
  logic [TW-1:0] lookupTag = '0;
  logic          lookupRvalid;
  logic          lookupHit;

  logic          preload = 1'b1;
  logic [DW-1:0] mem [NSETS];
  bit            refValid [NSETS];
  logic [TW-1:0] refTag [NSETS];
  bit            expQ [$];
  bit            rvDue = 1'b0;
  int            total = 0;
  int            bad = 0;

  always #5 clk = ~clk;

  tag_scm_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) tagBus ();

  tag_scm_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush_req_i     (flushReq),
    .flush_ack_o     (flushAck),
    .busy_o          (busy),
    .refill_req_i    (refillReq),
    .refill_gnt_o    (refillGnt),
    .refill_index_i  (refillIndex),
    .refill_tag_i    (refillTag),
    .lookup_req_i    (lookupReq),
    .lookup_gnt_o    (lookupGnt),
    .lookup_index_i  (lookupIndex),
    .lookup_tag_i    (lookupTag),
    .lookup_rvalid_o (lookupRvalid),
    .lookup_hit_o    (lookupHit),
    .tag_if          (tagBus)
  );

  // Tag memory: preloaded with valid non-zero entries so the reset sweep has
  // something to clear; reads return data one cycle after the request.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < NSETS; i++) begin
        mem[i] <= {1'b1, AW'(i) ^ 6'h15};
      end
      tagBus.tag_rdata_i <= '0;
    end else if (tagBus.tag_req_o) begin
      if (tagBus.tag_write_o) begin
        mem[tagBus.tag_addr_o] <= tagBus.tag_wdata_o;
      end else begin
        tagBus.tag_rdata_i <= mem[tagBus.tag_addr_o];
      end
    end
  end

  task automatic compare(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Each cycle: rvalid must appear exactly when a grant was expected the
  // cycle before, and its hit must match the oldest queued expectation.
  task automatic checkOutput();
    bit expHit;
    compare("rvalid", lookupRvalid, rvDue);
    if (lookupRvalid && expQ.size() > 0) begin
      expHit = expQ.pop_front();
      compare("lookup_hit", lookupHit, expHit);
    end else begin
      compare("hit_unqualified", lookupHit, 0);
    end
    rvDue = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  // Drives one cycle of requests and checks the grants and the bus they
  // produce; granted refills update the model, granted lookups queue a result.
  task automatic applyStimulus(input bit fl, input bit rf, input logic [AW-1:0] rIdx,
                               input logic [TW-1:0] rTg, input bit lk, input logic [AW-1:0] lIdx,
                               input logic [TW-1:0] lTg, input bit expRef, input bit expLk);
    flushReq    = fl;
    refillReq   = rf;
    refillIndex = rIdx;
    refillTag   = rTg;
    lookupReq   = lk;
    lookupIndex = lIdx;
    lookupTag   = lTg;
    #1;
    compare("refill_gnt", refillGnt, expRef);
    compare("lookup_gnt", lookupGnt, expLk);
    if (expRef) begin
      compare("refill_bus", {tagBus.tag_req_o, tagBus.tag_write_o, tagBus.tag_addr_o, tagBus.tag_wdata_o},
              {2'b11, rIdx, 1'b1, rTg});
      refValid[rIdx] = 1'b1;
      refTag[rIdx]   = rTg;
    end else if (expLk) begin
      compare("lookup_bus", {tagBus.tag_req_o, tagBus.tag_write_o, tagBus.tag_addr_o}, {2'b10, lIdx});
      expQ.push_back(refValid[lIdx] && (refTag[lIdx] == lTg));
      rvDue = 1'b1;
    end else begin
      compare("no_access", tagBus.tag_req_o, 0);
    end
  endtask

  // Follows a sweep from its first cycle to the first IDLE cycle.
  task automatic sweepCheck(input string name, input bit expectAck);
    int cycles = 0;
    bit busOk  = 1'b1;
    bit quiet  = 1'b1;
    for (int i = 0; i < NSETS; i++) begin
      refValid[i] = 1'b0;
      refTag[i]   = '0;
    end
    while (busy && cycles < 200) begin
      if (!(tagBus.tag_req_o && tagBus.tag_write_o && tagBus.tag_addr_o == AW'(cycles) &&
            tagBus.tag_wdata_o == '0)) busOk = 1'b0;
      if (refillGnt || lookupGnt || flushAck) quiet = 1'b0;
      tick();
      cycles++;
    end
    compare({name, "_cycles"}, cycles, NSETS);
    compare({name, "_bus"}, busOk, 1);
    compare({name, "_quiet"}, quiet, 1);
    compare({name, "_ack"}, flushAck, expectAck);
  endtask

  initial begin
    int guard;
    // Reset with requests pending: nothing may be granted or driven.
    applyStimulus(0, 1, 6'd3, 6'h01, 1, 6'd3, 6'h01, 0, 0);
    tick();
    tick();
    preload = 1'b0;
    compare("rst_ack", flushAck, 0);
    compare("rst_busy", busy, 1);
    compare("rst_bus", {tagBus.tag_req_o, tagBus.tag_write_o, tagBus.tag_addr_o, tagBus.tag_wdata_o}, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    sweepCheck("reset_sweep", 0);

    // Refill then hit/miss lookups on the same set.
    applyStimulus(0, 1, 6'd5, 6'h2A, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 6'd5, 6'h2A, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 6'd5, 6'h2B, 0, 1);
    tick();

    // Refill beats a same-cycle lookup; the lookup goes next cycle.
    applyStimulus(0, 1, 6'd7, 6'h11, 1, 6'd7, 6'h11, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 6'd7, 6'h11, 0, 1);
    tick();

    // Back-to-back lookups: hit, tag miss, invalid entry with matching tag.
    applyStimulus(0, 1, 6'd1, 6'h01, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 1, 6'd2, 6'h02, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 6'd1, 6'h01, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 6'd2, 6'h03, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 6'd3, 6'h00, 0, 1);
    tick();

    // Read-before-write on set 5, then the new contents hit.
    applyStimulus(0, 0, 0, 0, 1, 6'd5, 6'h2A, 0, 1);
    tick();
    applyStimulus(0, 1, 6'd5, 6'h15, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 6'd5, 6'h15, 0, 1);
    tick();

    // Flush with a lookup granted just before it; all requests held high.
    applyStimulus(0, 1, 6'd9, 6'h33, 0, 0, 0, 1, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 1, 6'd9, 6'h33, 0, 1);
    tick();
    applyStimulus(1, 1, 6'd0, 6'h3F, 1, 6'd9, 6'h33, 0, 0);
    tick();
    compare("flush_busy", busy, 1);
    sweepCheck("flush_sweep", 1);
    applyStimulus(1, 0, 0, 0, 1, 6'd9, 6'h33, 0, 1);
    tick();
    compare("ack_once", flushAck, 0);
    compare("flush_held_ignored", busy, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    compare("flush_needs_low", busy, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // New flush, interrupted by reset at address 30.
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    flushReq = 1'b0;
    compare("reflush_busy", busy, 1);
    guard = 0;
    while (tagBus.tag_addr_o != 6'd30 && guard < 100) begin
      tick();
      guard++;
    end
    compare("abort_addr", tagBus.tag_addr_o, 30);
    rst_n = 1'b0;
    #1;
    compare("abort_busy", busy, 1);
    compare("abort_bus_quiet", tagBus.tag_req_o, 0);
    tick();
    rst_n = 1'b1;
    #1;
    sweepCheck("abort_sweep", 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd9, 6'h33, 0, 1);
    tick();
    compare("abort_no_ack", flushAck, 0);
    applyStimulus(0, 0, 0, 0, 1, 6'd5, 6'h15, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    compare("scoreboard_drained", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
